core_mem_ctl: RTL and testbench



---
 rtl/core_pkg.sv | 25 ++
 rtl/core_mem_ctl_if.sv | 33 +++
 rtl/rr_arb.sv | 25 ++
 rtl/core_mem_ctl.sv | 185 ++++++++++++++++++
 tb/tb_core_mem_ctl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared constants and state encoding for the core memory controller.
package core_pkg;

  localparam int unsigned CoreAddrW = 18;  // Avalon word address width
  localparam int unsigned WordW     = 36;  // memory word width
  localparam int unsigned SelW      = 4;   // memory select jumper width per port
  localparam int unsigned IlvMax    = 2;   // largest supported interleave log2

  typedef enum logic [2:0] {
    StIdle,
    StAck,
    StRd,
    StRs,
    StWwait,
    StWr,
    StDone,
    StStop
  } state_t;

  // Index width for a vector of n entries; never less than one bit.
  function automatic int unsigned idx_w(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_mem_ctl_if.sv
// Memory bus bundle: one bit or one slice per port for every signal.
interface core_mem_ctl_if
#(
  parameter int unsigned NPORT = 4,
  parameter int unsigned MA_W  = 15
);
  import core_pkg::*;

  logic [NPORT-1:0]       rq_cyc;
  logic [NPORT-1:0]       rd_rq;
  logic [NPORT-1:0]       wr_rq;
  logic [NPORT-1:0]       wr_rs;
  logic [NPORT-1:0]       fmc_select;
  logic [NPORT*MA_W-1:0]  ma;
  logic [NPORT*SelW-1:0]  sel;
  logic [NPORT*WordW-1:0] mb_in;
  logic [NPORT-1:0]       addr_ack;
  logic [NPORT-1:0]       rd_rs;
  logic [NPORT*WordW-1:0] mb_out;

  // Processor side of the bus.
  modport master (
    output rq_cyc, rd_rq, wr_rq, wr_rs, fmc_select, ma, sel, mb_in,
    input  addr_ack, rd_rs, mb_out
  );

  // Memory side of the bus.
  modport slave (
    input  rq_cyc, rd_rq, wr_rq, wr_rs, fmc_select, ma, sel, mb_in,
    output addr_ack, rd_rs, mb_out
  );

endinterface

// File: rtl/rr_arb.sv
// Rotating-priority arbiter: search begins at the entry after 'last'.
module rr_arb
#(
  parameter int unsigned N = 4,
  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant,
  output logic          valid
);

  // First requester found walking upward from last+1, wrapping at N.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      if (!valid && req[LW'((32'(last) + off) % N)]) begin
        grant[LW'((32'(last) + off) % N)] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_mem_ctl.sv
// Multi-port core memory controller bridging the memory bus to an Avalon master.
module core_mem_ctl
  import core_pkg::*;
#(
  parameter int unsigned            NPORT   = 4,
  parameter int unsigned            MA_W    = 15,
  parameter logic [NPORT*SelW-1:0]  MEMSEL  = '0,
  parameter int unsigned            ILV     = 0,
  parameter int unsigned            ILV_SEL = 0,
  parameter int unsigned            WR_TMO  = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  core_mem_ctl_if.slave        membus,
  input  logic                 sw_single_step,
  input  logic                 sw_restart,
  output logic [CoreAddrW-1:0] m_address,
  output logic                 m_read,
  output logic                 m_write,
  output logic [WordW-1:0]     m_writedata,
  input  logic [WordW-1:0]     m_readdata,
  input  logic                 m_waitrequest,
  output logic                 busy
);

  localparam int unsigned    PW      = idx_w(NPORT);
  localparam int unsigned    TW      = $clog2(WR_TMO + 1);
  localparam logic [MA_W-1:0] IlvMask = MA_W'((1 << ILV) - 1);

  state_t                 state_q;
  logic [PW-1:0]          port_q;
  logic [PW-1:0]          last_q;
  logic [CoreAddrW-1:0]   addr_q;
  logic                   rd_q;
  logic                   wr_q;
  logic [WordW-1:0]       rdata_q;
  logic [WordW-1:0]       wdata_q;
  logic [TW-1:0]          tmo_q;
  logic                   ss_q;
  logic                   restart_q;
  logic [NPORT-1:0]       addr_ack_q;
  logic [NPORT-1:0]       rd_rs_q;
  logic                   m_read_q;
  logic                   m_write_q;

  logic [NPORT-1:0]       req;
  logic [NPORT-1:0]       grant;
  logic                   grant_valid;
  logic [PW-1:0]          grant_idx;
  logic [WordW*NPORT-1:0] mb_out_w;

  // A port is a candidate only if it targets this module's jumpers and bank.
  always_comb begin
    req = '0;
    for (int i = 0; i < NPORT; i++) begin
      req[i] = membus.rq_cyc[i] & ~membus.fmc_select[i]
             & (membus.sel[i*SelW +: SelW] == MEMSEL[i*SelW +: SelW])
             & ((membus.ma[i*MA_W +: MA_W] & IlvMask) == MA_W'(ILV_SEL));
    end
  end

  rr_arb #(
    .N (NPORT)
  ) u_arb (
    .req   (req),
    .last  (last_q),
    .grant (grant),
    .valid (grant_valid)
  );

  // One-hot grant to port index.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (grant[i]) grant_idx = PW'(i);
    end
  end

  // Main cycle sequencer; every bus and Avalon output is a register here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      port_q     <= '0;
      last_q     <= PW'(NPORT - 1);
      addr_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      rdata_q    <= '0;
      wdata_q    <= '0;
      tmo_q      <= '0;
      ss_q       <= 1'b0;
      restart_q  <= 1'b0;
      addr_ack_q <= '0;
      rd_rs_q    <= '0;
      m_read_q   <= 1'b0;
      m_write_q  <= 1'b0;
    end else begin
      restart_q <= sw_restart;
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            port_q     <= grant_idx;
            last_q     <= grant_idx;
            addr_q     <= CoreAddrW'(membus.ma[grant_idx*MA_W +: MA_W] >> ILV);
            rd_q       <= membus.rd_rq[grant_idx];
            wr_q       <= membus.wr_rq[grant_idx];
            addr_ack_q <= grant;
            state_q    <= StAck;
          end
        end
        StAck: begin
          addr_ack_q <= '0;
          if (sw_single_step) ss_q <= 1'b1;
          tmo_q <= '0;
          if (rd_q) begin
            m_read_q <= 1'b1;
            state_q  <= StRd;
          end else if (wr_q) begin
            state_q <= StWwait;
          end else begin
            state_q <= StDone;
          end
        end
        StRd: begin
          if (!m_waitrequest) begin
            rdata_q  <= m_readdata;
            m_read_q <= 1'b0;
            rd_rs_q  <= NPORT'(1) << port_q;
            state_q  <= StRs;
          end
        end
        StRs: begin
          rd_rs_q <= '0;
          state_q <= wr_q ? StWwait : StDone;
        end
        StWwait: begin
          // wr_rs is checked first so it wins in the expiry cycle.
          if (membus.wr_rs[port_q]) begin
            wdata_q   <= membus.mb_in[port_q*WordW +: WordW];
            m_write_q <= 1'b1;
            state_q   <= StWr;
          end else if (tmo_q == TW'(WR_TMO - 1)) begin
            state_q <= StDone;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StWr: begin
          if (!m_waitrequest) begin
            m_write_q <= 1'b0;
            state_q   <= StDone;
          end
        end
        StDone: begin
          state_q <= ss_q ? StStop : StIdle;
        end
        StStop: begin
          if (sw_restart && !restart_q) begin
            ss_q    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read data appears only on the granted port, only during the rd_rs pulse.
  always_comb begin
    mb_out_w = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (rd_rs_q[i]) mb_out_w[i*WordW +: WordW] = rdata_q;
    end
  end

  assign membus.addr_ack = addr_ack_q;
  assign membus.rd_rs    = rd_rs_q;
  assign membus.mb_out   = mb_out_w;
  assign m_address       = addr_q;
  assign m_read          = m_read_q;
  assign m_write         = m_write_q;
  assign m_writedata     = wdata_q;
  assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_core_mem_ctl.sv
// Directed self-checking bench for core_mem_ctl.
module tb_core_mem_ctl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  core_mem_ctl_if #(.NPORT(4), .MA_W(15)) bus0 ();
  core_mem_ctl_if #(.NPORT(4), .MA_W(15)) bus1 ();

  logic        sw_single_step, sw_restart;
  logic [17:0] m_address0, m_address1;
  logic        m_read0, m_write0, m_read1, m_write1;
  logic [35:0] m_writedata0, m_writedata1, m_readdata0, m_readdata1;
  logic        m_waitrequest0, m_waitrequest1;
  logic        busy0, busy1;

  int passed = 0;
  int total = 0;

  // Avalon slave model for dut0: ws_n wait states per transfer.
  int ws_n = 0;
  int ws_cnt;
  int rd_cnt = 0, wr_cnt = 0, wr_hi_cnt = 0;
  logic [17:0] rd_addr, wr_addr;
  logic [35:0] wr_data;

  assign m_waitrequest0 = (ws_cnt < ws_n);
  assign m_waitrequest1 = 1'b0;
  assign m_readdata1    = 36'd0;

  always @(posedge clk or negedge reset) begin
    if (!reset) ws_cnt <= 0;
    else if (m_read0 || m_write0) ws_cnt <= ws_cnt + 1;
    else ws_cnt <= 0;
  end

  always @(posedge clk) begin
    if (m_write0) wr_hi_cnt <= wr_hi_cnt + 1;
    if (m_read0 && !m_waitrequest0) begin
      rd_cnt  <= rd_cnt + 1;
      rd_addr <= m_address0;
    end
    if (m_write0 && !m_waitrequest0) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= m_address0;
      wr_data <= m_writedata0;
    end
  end

  core_mem_ctl #(
    .NPORT (4), .MA_W (15), .MEMSEL (16'h0000), .ILV (0), .ILV_SEL (0), .WR_TMO (1023)
  ) dut0 (
    .clk (clk), .reset (reset), .membus (bus0),
    .sw_single_step (sw_single_step), .sw_restart (sw_restart),
    .m_address (m_address0), .m_read (m_read0), .m_write (m_write0),
    .m_writedata (m_writedata0), .m_readdata (m_readdata0),
    .m_waitrequest (m_waitrequest0), .busy (busy0)
  );

  core_mem_ctl #(
    .NPORT (4), .MA_W (15), .MEMSEL (16'h0050), .ILV (1), .ILV_SEL (1), .WR_TMO (1023)
  ) dut1 (
    .clk (clk), .reset (reset), .membus (bus1),
    .sw_single_step (1'b0), .sw_restart (1'b0),
    .m_address (m_address1), .m_read (m_read1), .m_write (m_write1),
    .m_writedata (m_writedata1), .m_readdata (m_readdata1),
    .m_waitrequest (m_waitrequest1), .busy (busy1)
  );

  task automatic clear_inputs();
    bus0.rq_cyc = '0; bus0.rd_rq = '0; bus0.wr_rq = '0; bus0.wr_rs = '0;
    bus0.fmc_select = '0; bus0.ma = '0; bus0.sel = '0; bus0.mb_in = '0;
    bus1.rq_cyc = '0; bus1.rd_rq = '0; bus1.wr_rq = '0; bus1.wr_rs = '0;
    bus1.fmc_select = '0; bus1.ma = '0; bus1.sel = '0; bus1.mb_in = '0;
    sw_single_step = 1'b0;
    sw_restart = 1'b0;
    m_readdata0 = '0;
    ws_n = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    total++;
    if ({busy0, m_read0, m_write0, busy1} !== 4'b0000)
      $display("FAIL reset_ctl busy/read/write/busy1=%b required 0000",
               {busy0, m_read0, m_write0, busy1});
    else passed++;
    total++;
    if ({bus0.addr_ack, bus0.rd_rs} !== 8'h00)
      $display("FAIL reset_ack_rs got %h required 00", {bus0.addr_ack, bus0.rd_rs});
    else passed++;
    total++;
    if ({m_address0, m_writedata0} !== 54'd0)
      $display("FAIL reset_addr_data got %h required 0", {m_address0, m_writedata0});
    else passed++;
    total++;
    if (bus0.mb_out !== 144'd0)
      $display("FAIL reset_mb_out got %h required 0", bus0.mb_out);
    else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read();
    logic [35:0]  data = 36'o123456701234;
    logic [143:0] exp_mb = '0;
    logic [3:0]   ack = '0, rs = '0;
    logic [143:0] mb = '0;
    int busy_cyc = 0, ack_cyc = 0, rd0, wh0;
    exp_mb[72 +: 36] = data;
    apply_reset();
    ws_n = 2;
    m_readdata0 = data;
    rd0 = rd_cnt;
    wh0 = wr_hi_cnt;
    bus0.ma[2*15 +: 15] = 15'o12345;
    bus0.rd_rq[2] = 1'b1;
    bus0.rq_cyc[2] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy0) busy_cyc++;
      if (bus0.addr_ack != 0) begin
        ack_cyc++;
        ack = bus0.addr_ack;
        bus0.rq_cyc = '0;
        bus0.rd_rq = '0;
      end
      if (bus0.rd_rs != 0) begin
        rs = bus0.rd_rs;
        mb = bus0.mb_out;
      end
    end
    total++;
    if (ack !== 4'b0100 || ack_cyc != 1)
      $display("FAIL read_ack got %b x%0d required 0100 x1", ack, ack_cyc);
    else passed++;
    total++;
    if (rd_cnt - rd0 != 1 || rd_addr !== 18'o12345)
      $display("FAIL read_avalon got %0d reads addr %o required 1 addr 12345",
               rd_cnt - rd0, rd_addr);
    else passed++;
    total++;
    if (rs !== 4'b0100 || mb !== exp_mb)
      $display("FAIL read_rs got rs=%b mb=%h required rs=0100 mb=%h", rs, mb, exp_mb);
    else passed++;
    total++;
    if (wr_hi_cnt != wh0)
      $display("FAIL read_no_write got %0d write cycles required 0", wr_hi_cnt - wh0);
    else passed++;
    total++;
    if (busy_cyc != 6)
      $display("FAIL read_length got %0d busy cycles required 6", busy_cyc);
    else passed++;
  endtask

  task automatic test_rmw();
    logic [35:0] data = 36'o777000777000;
    logic [3:0]  rs = '0;
    int rs_at = -1, rd0, wr0, wr_early = 0;
    apply_reset();
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    bus0.ma[0 +: 15] = 15'o00100;
    bus0.rd_rq[0] = 1'b1;
    bus0.wr_rq[0] = 1'b1;
    bus0.rq_cyc[0] = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      bus0.wr_rs = '0;
      if (bus0.addr_ack != 0) begin
        bus0.rq_cyc = '0; bus0.rd_rq = '0; bus0.wr_rq = '0;
      end
      if (bus0.rd_rs != 0 && rs_at < 0) begin
        rs = bus0.rd_rs;
        rs_at = c;
      end
      if (rs_at >= 0 && c == rs_at + 2) begin
        bus0.wr_rs[1] = 1'b1;
        bus0.mb_in[36 +: 36] = 36'o111111111111;
      end
      if (rs_at >= 0 && c == rs_at + 5) begin
        wr_early = wr_cnt - wr0;
        bus0.wr_rs[0] = 1'b1;
        bus0.mb_in[0 +: 36] = data;
      end
    end
    total++;
    if (rs !== 4'b0001 || rd_cnt - rd0 != 1 || rd_addr !== 18'o100)
      $display("FAIL rmw_read got rs=%b reads=%0d addr=%o required 0001 1 100",
               rs, rd_cnt - rd0, rd_addr);
    else passed++;
    total++;
    if (wr_early != 0)
      $display("FAIL rmw_wait got %0d writes before wr_rs required 0", wr_early);
    else passed++;
    total++;
    if (wr_cnt - wr0 != 1 || wr_addr !== 18'o100 || wr_data !== data)
      $display("FAIL rmw_write got %0d writes addr=%o data=%o required 1 100 %o",
               wr_cnt - wr0, wr_addr, wr_data, data);
    else passed++;
    total++;
    if (busy0 !== 1'b0)
      $display("FAIL rmw_idle got busy=%b required 0", busy0);
    else passed++;
  endtask

  task automatic test_contention();
    int exp_order[6] = '{0, 1, 3, 0, 1, 3};
    int got[6] = '{99, 99, 99, 99, 99, 99};
    int n = 0;
    apply_reset();
    bus0.rq_cyc = 4'b1011;
    bus0.rd_rq = 4'b1011;
    for (int c = 0; c < 100 && n < 6; c++) begin
      @(negedge clk);
      if (bus0.addr_ack != 0) begin
        for (int i = 0; i < 4; i++) if (bus0.addr_ack == (4'b0001 << i)) got[n] = i;
        n++;
      end
    end
    bus0.rq_cyc = '0;
    bus0.rd_rq = '0;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (got[k] != exp_order[k])
        $display("FAIL contention_grant%0d got port %0d required port %0d",
                 k, got[k], exp_order[k]);
      else passed++;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_filter();
    logic [3:0]  sel_v[3] = '{4'd0, 4'd5, 4'd5};
    logic [14:0] ma_v[3]  = '{15'o3, 15'o2, 15'o3};
    logic        fmc_v[3] = '{1'b0, 1'b0, 1'b1};
    int hits;
    logic [3:0]  ack = '0;
    logic [17:0] addr = '1;
    apply_reset();
    bus1.rq_cyc[1] = 1'b1;
    bus1.rd_rq[1] = 1'b1;
    for (int p = 0; p < 3; p++) begin
      bus1.sel[4 +: 4] = sel_v[p];
      bus1.ma[15 +: 15] = ma_v[p];
      bus1.fmc_select[1] = fmc_v[p];
      hits = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (bus1.addr_ack != 0 || busy1) hits++;
      end
      total++;
      if (hits != 0)
        $display("FAIL filter_case%0d got %0d active cycles required 0", p, hits);
      else passed++;
    end
    bus1.fmc_select[1] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus1.addr_ack != 0) begin
        ack = bus1.addr_ack;
        bus1.rq_cyc = '0;
        bus1.rd_rq = '0;
      end
      if (m_read1) addr = m_address1;
    end
    total++;
    if (ack !== 4'b0010 || addr !== 18'd1)
      $display("FAIL filter_accept got ack=%b addr=%0d required 0010 1", ack, addr);
    else passed++;
  endtask

  task automatic test_timeout();
    int exp_busy[2] = '{1025, 1026};
    int exp_wr[2]   = '{0, 1};
    for (int run = 0; run < 2; run++) begin
      int busy_cyc = 0, wr0, wh0;
      logic acked = 1'b0, ended = 1'b0;
      apply_reset();
      wr0 = wr_cnt;
      wh0 = wr_hi_cnt;
      bus0.mb_in[36 +: 36] = 36'o525252525252;
      bus0.wr_rq[1] = 1'b1;
      bus0.rq_cyc[1] = 1'b1;
      for (int c = 0; c < 1200 && !ended; c++) begin
        @(negedge clk);
        bus0.wr_rs = '0;
        if (busy0) busy_cyc++;
        if (bus0.addr_ack != 0) begin
          acked = 1'b1;
          bus0.rq_cyc = '0;
          bus0.wr_rq = '0;
        end
        if (acked && !busy0) ended = 1'b1;
        if (run == 1 && busy0 && busy_cyc == 1024) bus0.wr_rs[1] = 1'b1;
      end
      total++;
      if (!ended || busy_cyc != exp_busy[run])
        $display("FAIL timeout_run%0d got %0d busy cycles ended=%b required %0d",
                 run, busy_cyc, ended, exp_busy[run]);
      else passed++;
      total++;
      if (wr_cnt - wr0 != exp_wr[run] || (run == 0 && wr_hi_cnt != wh0))
        $display("FAIL timeout_write%0d got %0d writes required %0d",
                 run, wr_cnt - wr0, exp_wr[run]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_rd();
    logic seen = 1'b0;
    apply_reset();
    ws_n = 1000;
    bus0.rd_rq[0] = 1'b1;
    bus0.rq_cyc[0] = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (m_read0) seen = 1'b1;
    end
    reset = 1'b0;
    #1;
    total++;
    if (!seen || m_read0 !== 1'b0 || busy0 !== 1'b0)
      $display("FAIL reset_mid_rd got seen=%b m_read=%b busy=%b required 1 0 0",
               seen, m_read0, busy0);
    else passed++;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_step();
    int acks = 0;
    apply_reset();
    sw_single_step = 1'b1;
    bus0.rd_rq[3] = 1'b1;
    bus0.rq_cyc[3] = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus0.addr_ack != 0) begin
        bus0.rq_cyc = '0;
        bus0.rd_rq = '0;
      end
    end
    sw_single_step = 1'b0;
    bus0.rd_rq[0] = 1'b1;
    bus0.rq_cyc[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus0.addr_ack != 0) acks++;
    end
    total++;
    if (busy0 !== 1'b1 || acks != 0)
      $display("FAIL step_stop got busy=%b acks=%0d required 1 0", busy0, acks);
    else passed++;
    sw_restart = 1'b1;
    @(negedge clk);
    total++;
    if (busy0 !== 1'b0)
      $display("FAIL step_restart got busy=%b required 0", busy0);
    else passed++;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus0.addr_ack != 0) begin
        acks++;
        bus0.rq_cyc = '0;
        bus0.rd_rq = '0;
      end
    end
    total++;
    if (acks != 1 || busy0 !== 1'b0)
      $display("FAIL step_cleared got acks=%0d busy=%b required 1 0", acks, busy0);
    else passed++;
    sw_restart = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_read();
    test_rmw();
    test_contention();
    test_filter();
    test_timeout();
    test_reset_mid_rd();
    test_single_step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500us;
    $display("FAIL watchdog expired after %0d/%0d checks", passed, total);
    $fatal(1);
  end

endmodule
